// File: rtl/carrd_wb_pkg.sv
// Shared constants and the default writeback entry type for the Carrd
// vector writeback arbiter.
package carrd_wb_pkg;

    localparam int unsigned NUM_SRC_DEF    = 5;
    localparam int unsigned NUM_LANES_DEF  = 4;
    localparam int unsigned LANE_W_DEF     = 128;
    localparam int unsigned ADDR_W_DEF     = 5;
    localparam int unsigned FIFO_DEPTH_DEF = 2;
    localparam int unsigned ELEM_W         = 32;

    // One buffered result for the default configuration.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0]                vd;
        logic [NUM_LANES_DEF*LANE_W_DEF-1:0]  data;
        logic [NUM_LANES_DEF-1:0]             mask;
        logic                                 elem;
    } wb_entry_t;

endpackage

// File: rtl/carrd_wb_fifo.sv
// Single-source result FIFO: registered count, wrapping pointers, sync flush.
module carrd_wb_fifo
    import carrd_wb_pkg::*;
#(
    parameter int unsigned DEPTH   = FIFO_DEPTH_DEF,
    parameter type         entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  entry_t wr_entry,
    input  logic   pop,
    output entry_t rd_entry,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            count <= CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
        end
    end

endmodule

// File: rtl/carrd_wb_arbiter.sv
// Vector writeback stage: per-source result FIFOs, round-robin arbitration,
// and one registered VRF write port (register or single-element writes).
module carrd_wb_arbiter
    import carrd_wb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
    parameter int unsigned NUM_LANES  = NUM_LANES_DEF,
    parameter int unsigned LANE_W     = LANE_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0]        src_vd,
    input  logic [NUM_SRC*NUM_LANES*LANE_W-1:0] src_data,
    input  logic [NUM_SRC*NUM_LANES-1:0]     src_lane_mask,
    input  logic [NUM_SRC-1:0]               src_elem,
    output logic                             reg_wr_en,
    output logic                             el_wr_en,
    output logic [ADDR_W-1:0]                wb_vd,
    output logic [NUM_LANES-1:0]             wb_lane_en,
    output logic [NUM_LANES*LANE_W-1:0]      wb_data,
    output logic                             pending
);

    localparam int unsigned DATA_W = NUM_LANES * LANE_W;
    localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0]    vd;
        logic [DATA_W-1:0]    data;
        logic [NUM_LANES-1:0] mask;
        logic                 elem;
    } wb_slot_t;

    wb_slot_t         wr_slot [NUM_SRC];
    wb_slot_t         rd_slot [NUM_SRC];
    wb_slot_t         sel;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] pop;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    int unsigned      cand;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign wr_slot[g] = {src_vd[g*ADDR_W +: ADDR_W],
                             src_data[g*DATA_W +: DATA_W],
                             src_lane_mask[g*NUM_LANES +: NUM_LANES],
                             src_elem[g]};
        assign pop[g]       = grant_valid && (grant_idx == IDX_W'(g));
        assign src_ready[g] = !full[g];

        carrd_wb_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (wb_slot_t)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (src_valid[g]),
            .wr_entry (wr_slot[g]),
            .pop      (pop[g]),
            .rd_entry (rd_slot[g]),
            .full     (full[g]),
            .empty    (empty[g])
        );
    end

    // Round-robin: first non-empty source after the last granted index.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_SRC;
            if (!grant_valid && !empty[IDX_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    assign sel     = rd_slot[grant_idx];
    assign pending = !(&empty) || reg_wr_en || el_wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= IDX_W'(NUM_SRC - 1);
            reg_wr_en  <= 1'b0;
            el_wr_en   <= 1'b0;
            wb_lane_en <= '0;
            wb_vd      <= '0;
            wb_data    <= '0;
        end else if (flush) begin
            rr_ptr     <= IDX_W'(NUM_SRC - 1);
            reg_wr_en  <= 1'b0;
            el_wr_en   <= 1'b0;
            wb_lane_en <= '0;
        end else if (grant_valid) begin
            rr_ptr <= grant_idx;
            wb_vd  <= sel.vd;
            if (sel.elem) begin
                reg_wr_en  <= 1'b0;
                el_wr_en   <= 1'b1;
                wb_lane_en <= NUM_LANES'(1'b1);
                wb_data    <= DATA_W'(sel.data[ELEM_W-1:0]);
            end else begin
                // An all-zero mask still consumes the entry but writes nothing.
                reg_wr_en  <= |sel.mask;
                el_wr_en   <= 1'b0;
                wb_lane_en <= sel.mask;
                wb_data    <= sel.data;
            end
        end else begin
            reg_wr_en  <= 1'b0;
            el_wr_en   <= 1'b0;
            wb_lane_en <= '0;
        end
    end

endmodule

// File: tb/tb_carrd_wb_arbiter.sv
// Directed bench for carrd_wb_arbiter with hand-derived expectations.
`timescale 1ns/1ps
module tb_carrd_wb_arbiter;

    localparam int NS = 5;
    localparam int NL = 4;
    localparam int LW = 128;
    localparam int AW = 5;
    localparam int DW = NL * LW;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*AW-1:0]  src_vd;
    logic [NS*DW-1:0]  src_data;
    logic [NS*NL-1:0]  src_lane_mask;
    logic [NS-1:0]     src_elem;
    logic              reg_wr_en;
    logic              el_wr_en;
    logic [AW-1:0]     wb_vd;
    logic [NL-1:0]     wb_lane_en;
    logic [DW-1:0]     wb_data;
    logic              pending;

    int vectors = 0;
    int errors  = 0;
    int exp_q [NS][$];

    carrd_wb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_vd        (src_vd),
        .src_data      (src_data),
        .src_lane_mask (src_lane_mask),
        .src_elem      (src_elem),
        .reg_wr_en     (reg_wr_en),
        .el_wr_en      (el_wr_en),
        .wb_vd         (wb_vd),
        .wb_lane_en    (wb_lane_en),
        .wb_data       (wb_data),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk_data(input int v);
        logic [DW-1:0] d;
        d = '0;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = 32'h5A000000 | (32'(v) << 8) | 32'(w);
        return d;
    endfunction

    task automatic set_src(input int i, input logic v, input logic [AW-1:0] vd,
                           input logic [DW-1:0] d, input logic [NL-1:0] m, input logic e);
        src_valid[i]              = v;
        src_vd[i*AW +: AW]        = vd;
        src_data[i*DW +: DW]      = d;
        src_lane_mask[i*NL +: NL] = m;
        src_elem[i]               = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0;
        src_valid = '0; src_vd = '0; src_data = '0; src_lane_mask = '0; src_elem = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        src_valid = '0; src_vd = '0; src_data = '0; src_lane_mask = '0; src_elem = '0;
        tick();
        vectors++; if (src_ready !== 5'b11111) begin errors++; $display("FAIL reset_ready: got %b want 11111", src_ready); end
        vectors++; if (reg_wr_en !== 1'b0 || el_wr_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b%b want 00", reg_wr_en, el_wr_en); end
        vectors++; if (wb_lane_en !== 4'b0000 || wb_vd !== 5'd0) begin errors++; $display("FAIL reset_lane_vd: got %b/%0d want 0000/0", wb_lane_en, wb_vd); end
        vectors++; if (wb_data !== '0 || pending !== 1'b0) begin errors++; $display("FAIL reset_data_pend: got %0h/%b want 0/0", wb_data, pending); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [DW-1:0] a;
        do_reset();
        a = mk_data(77);
        set_src(2, 1'b1, 5'd7, a, 4'b1111, 1'b0);
        tick();
        src_valid = '0;
        vectors++; if (reg_wr_en !== 1'b0 || pending !== 1'b1) begin errors++; $display("FAIL single_e0: got reg=%b pend=%b want 0/1", reg_wr_en, pending); end
        tick();
        vectors++; if (reg_wr_en !== 1'b1 || el_wr_en !== 1'b0) begin errors++; $display("FAIL single_en: got %b%b want 10", reg_wr_en, el_wr_en); end
        vectors++; if (wb_vd !== 5'd7 || wb_lane_en !== 4'b1111) begin errors++; $display("FAIL single_vd_lane: got %0d/%b want 7/1111", wb_vd, wb_lane_en); end
        vectors++; if (wb_data !== a) begin errors++; $display("FAIL single_data: got %0h want %0h", wb_data, a); end
        tick();
        vectors++; if (reg_wr_en !== 1'b0 || pending !== 1'b0 || wb_vd !== 5'd7) begin errors++; $display("FAIL single_done: got reg=%b pend=%b vd=%0d want 0/0/7", reg_wr_en, pending, wb_vd); end
    endtask

    task automatic test_contention();
        int ev;
        do_reset();
        for (int i = 0; i < NS; i++) set_src(i, 1'b1, 5'(10 + i), mk_data(10 + i), 4'b1111, 1'b0);
        tick();
        for (int i = 0; i < NS; i++) set_src(i, 1'b1, 5'(20 + i), mk_data(20 + i), 4'b1111, 1'b0);
        tick();
        src_valid = '0;
        vectors++; if (src_ready !== 5'b00001) begin errors++; $display("FAIL cont_ready: got %b want 00001", src_ready); end
        for (int k = 0; k < 10; k++) begin
            ev = (k < 5) ? 10 + k : 20 + (k - 5);
            vectors++;
            if (reg_wr_en !== 1'b1 || wb_vd !== 5'(ev) || wb_data !== mk_data(ev))
                begin errors++; $display("FAIL cont_grant%0d: got reg=%b vd=%0d want 1/%0d", k, reg_wr_en, wb_vd, ev); end
            tick();
        end
        vectors++; if (reg_wr_en !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL cont_idle: got reg=%b pend=%b want 0/0", reg_wr_en, pending); end
    endtask

    task automatic test_elem();
        logic [DW-1:0] d;
        do_reset();
        d = '1;
        d[31:0] = 32'hDEADBEEF;
        set_src(4, 1'b1, 5'd19, d, 4'b1010, 1'b1);
        tick();
        src_valid = '0;
        tick();
        vectors++; if (el_wr_en !== 1'b1 || reg_wr_en !== 1'b0) begin errors++; $display("FAIL elem_en: got el=%b reg=%b want 1/0", el_wr_en, reg_wr_en); end
        vectors++; if (wb_lane_en !== 4'b0001 || wb_vd !== 5'd19) begin errors++; $display("FAIL elem_lane_vd: got %b/%0d want 0001/19", wb_lane_en, wb_vd); end
        vectors++; if (wb_data !== 512'hDEADBEEF) begin errors++; $display("FAIL elem_data: got %0h want deadbeef", wb_data); end
    endtask

    task automatic test_backpressure();
        int sent [NS];
        int lim [NS];
        int nout, s, seq;
        logic [NS-1:0] rdy, vld;
        do_reset();
        nout = 0;
        for (int i = 0; i < NS; i++) begin
            sent[i] = 0; lim[i] = (i == 0) ? 4 : 6; exp_q[i].delete();
        end
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NS; i++)
                set_src(i, sent[i] < lim[i], 5'(i), mk_data(i * 16 + sent[i]), 4'b1111, 1'b0);
            rdy = src_ready; vld = src_valid;
            tick();
            for (int i = 0; i < NS; i++)
                if (vld[i] && rdy[i]) begin exp_q[i].push_back(sent[i]); sent[i]++; end
            if (c == 2) begin
                vectors++; if (src_ready !== 5'b00010) begin errors++; $display("FAIL bp_ready: got %b want 00010", src_ready); end
            end
            if (el_wr_en) begin vectors++; errors++; $display("FAIL bp_el: got el_wr_en=1 want 0"); end
            if (reg_wr_en) begin
                nout++;
                s = int'(wb_vd);
                vectors++;
                if (s >= NS || exp_q[s].size() == 0) begin
                    errors++; $display("FAIL bp_extra: got vd=%0d with nothing outstanding", s);
                end else begin
                    seq = exp_q[s].pop_front();
                    if (wb_data !== mk_data(s * 16 + seq)) begin
                        errors++; $display("FAIL bp_order: got %0h want src%0d seq%0d", wb_data[31:0], s, seq);
                    end
                end
            end
        end
        src_valid = '0;
        vectors++; if (nout !== 28) begin errors++; $display("FAIL bp_count: got %0d writes want 28", nout); end
        for (int i = 0; i < NS; i++) begin
            vectors++; if (exp_q[i].size() !== 0 || sent[i] !== lim[i]) begin errors++; $display("FAIL bp_src%0d: got left=%0d sent=%0d want 0/%0d", i, exp_q[i].size(), sent[i], lim[i]); end
        end
    endtask

    task automatic test_mask_zero();
        do_reset();
        set_src(0, 1'b1, 5'd3, mk_data(3), 4'b0000, 1'b0);
        set_src(1, 1'b1, 5'd5, mk_data(5), 4'b0110, 1'b0);
        tick();
        src_valid = '0;
        tick();
        vectors++; if (reg_wr_en !== 1'b0 || el_wr_en !== 1'b0 || wb_lane_en !== 4'b0000) begin errors++; $display("FAIL mz_none: got %b%b/%b want 00/0000", reg_wr_en, el_wr_en, wb_lane_en); end
        vectors++; if (pending !== 1'b1) begin errors++; $display("FAIL mz_pend: got %b want 1", pending); end
        tick();
        vectors++; if (reg_wr_en !== 1'b1 || wb_vd !== 5'd5 || wb_lane_en !== 4'b0110) begin errors++; $display("FAIL mz_next: got %b/%0d/%b want 1/5/0110", reg_wr_en, wb_vd, wb_lane_en); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) set_src(i, 1'b1, 5'(1 + i), mk_data(1 + i), 4'b1111, 1'b0);
        tick();
        src_valid = '0;
        set_src(3, 1'b1, 5'd4, mk_data(4), 4'b1111, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        src_valid = '0;
        vectors++; if (reg_wr_en !== 1'b0 || el_wr_en !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL flush_out: got %b%b pend=%b want 00/0", reg_wr_en, el_wr_en, pending); end
        vectors++; if (src_ready !== 5'b11111) begin errors++; $display("FAIL flush_ready: got %b want 11111", src_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (reg_wr_en !== 1'b0 || el_wr_en !== 1'b0) begin errors++; $display("FAIL flush_quiet%0d: got %b%b want 00", k, reg_wr_en, el_wr_en); end
        end
        set_src(2, 1'b1, 5'd9, mk_data(9), 4'b1111, 1'b0);
        set_src(0, 1'b1, 5'd8, mk_data(8), 4'b1111, 1'b0);
        tick();
        src_valid = '0;
        tick();
        vectors++; if (reg_wr_en !== 1'b1 || wb_vd !== 5'd8) begin errors++; $display("FAIL flush_ptr: got %b/%0d want 1/8", reg_wr_en, wb_vd); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < NS; i++) set_src(i, 1'b1, 5'(10 + i), mk_data(10 + i), 4'b1111, 1'b0);
        tick();
        src_valid = '0;
        tick();
        vectors++; if (reg_wr_en !== 1'b1 || wb_vd !== 5'd10) begin errors++; $display("FAIL ar_pre: got %b/%0d want 1/10", reg_wr_en, wb_vd); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (reg_wr_en !== 1'b0 || pending !== 1'b0 || wb_lane_en !== 4'b0000) begin errors++; $display("FAIL ar_out: got reg=%b pend=%b lane=%b want 0/0/0000", reg_wr_en, pending, wb_lane_en); end
        vectors++; if (wb_data !== '0 || wb_vd !== 5'd0 || src_ready !== 5'b11111) begin errors++; $display("FAIL ar_state: got vd=%0d ready=%b want 0/11111", wb_vd, src_ready); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_elem();
        test_backpressure();
        test_mask_zero();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
